// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite origin controller: detects entry into vertical blanking
// and moves the sprite (buttons or autonomous bounce) only while the screen is blanked.
module sprite_motion_ctrl #(
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480,
   parameter int SPRITE_W        = 64,
   parameter int SPRITE_H        = 64,
   parameter int STEP            = 4,
   parameter int FRAMES_PER_MOVE = 1,
   parameter int X_INIT          = 288,
   parameter int Y_INIT          = 208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pixelx,
   input  logic [9:0] pixely,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       auto_en,
   output logic [9:0] posx,
   output logic [9:0] posy,
   output logic       frame_tick
);

   localparam logic signed [10:0] XMAX_S = 11'(H_ACTIVE - SPRITE_W);
   localparam logic signed [10:0] YMAX_S = 11'(V_ACTIVE - SPRITE_H);
   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam int                 CNT_W  = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_MOVE - 1);

   typedef enum logic [1:0] {HOLD, ACTIVE, UPDATE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] frame_cnt_q;
   logic [9:0]       posx_q, posy_q;
   logic [9:0]       posx_d, posy_d;
   logic             dirx_q, diry_q;
   logic             dirx_d, diry_d;
   logic             frame_tick_q;
   // {auto_en, up, down, left, right}
   logic [4:0]       sync1_q, sync2_q;

   logic             vblank;
   logic             auto_s, up_s, down_s, left_s, right_s;
   logic signed [10:0] px, py;
   logic [10:0]      bnc_x, bnc_y;
   logic             unused_pixelx;

   assign vblank  = (pixely >= 10'(V_ACTIVE));
   assign {auto_s, up_s, down_s, left_s, right_s} = sync2_q;
   assign px      = {1'b0, posx_q};
   assign py      = {1'b0, posy_q};
   assign unused_pixelx = ^pixelx;

   function automatic logic [9:0] sat(input logic signed [10:0] v, input logic signed [10:0] hi);
      if (v < 11'sd0) return 10'd0;
      if (v > hi)     return 10'(hi);
      return 10'(v);
   endfunction

   // Exactly one of inc/dec moves the axis; both or neither leave it alone.
   function automatic logic [9:0] nudge(input logic signed [10:0] p, input logic inc,
                                         input logic dec, input logic signed [10:0] hi);
      if (inc ^ dec) return sat(inc ? (p + STEP_S) : (p - STEP_S), hi);
      return 10'(p);
   endfunction

   // Returns {new_dir, new_pos}; a wall hit pins the position and reverses direction.
   function automatic logic [10:0] bounce(input logic signed [10:0] p, input logic dir,
                                          input logic signed [10:0] hi);
      logic signed [10:0] n;
      n = p + STEP_S;
      if (dir) begin
         if (n >= hi) return {1'b0, 10'(hi)};
         return {1'b1, 10'(n)};
      end
      if (p <= STEP_S) return {1'b1, 10'd0};
      return {1'b0, 10'(p - STEP_S)};
   endfunction

   always_comb begin
      bnc_x  = bounce(px, dirx_q, XMAX_S);
      bnc_y  = bounce(py, diry_q, YMAX_S);
      posx_d = nudge(px, right_s, left_s, XMAX_S);
      posy_d = nudge(py, down_s, up_s, YMAX_S);
      dirx_d = dirx_q;
      diry_d = diry_q;
      if (auto_s) begin
         posx_d = bnc_x[9:0];
         posy_d = bnc_y[9:0];
         dirx_d = bnc_x[10];
         diry_d = bnc_y[10];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HOLD;
         frame_cnt_q  <= '0;
         posx_q       <= 10'(X_INIT);
         posy_q       <= 10'(Y_INIT);
         dirx_q       <= 1'b1;
         diry_q       <= 1'b1;
         frame_tick_q <= 1'b0;
         sync1_q      <= '0;
         sync2_q      <= '0;
      end else begin
         sync1_q      <= {auto_en, btn_up, btn_down, btn_left, btn_right};
         sync2_q      <= sync1_q;
         frame_tick_q <= 1'b0;
         case (state_q)
            // HOLD re-arms only once the scan is back in the visible area.
            HOLD: begin
               if (!vblank) state_q <= ACTIVE;
            end
            ACTIVE: begin
               if (vblank) begin
                  frame_tick_q <= 1'b1;
                  if (frame_cnt_q == CNT_LAST) begin
                     frame_cnt_q <= '0;
                     state_q     <= UPDATE;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 1'b1;
                     state_q     <= HOLD;
                  end
               end
            end
            UPDATE: begin
               posx_q  <= posx_d;
               posy_q  <= posy_d;
               dirx_q  <= dirx_d;
               diry_q  <= diry_d;
               state_q <= HOLD;
            end
            default: state_q <= HOLD;
         endcase
      end
   end

   assign posx       = posx_q;
   assign posy       = posy_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench: frame-level reference model predicts each tick and the origin it commits.
module tb_sprite_motion_ctrl;

   localparam int HA = 640, VA = 480, SW = 64, SH = 64;
   localparam int STEP = 4, FPM = 2, XI = 560, YI = 400;
   localparam int XMAX = HA - SW, YMAX = VA - SH;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] pixelx, pixely;
   logic       btn_up, btn_down, btn_left, btn_right, auto_en;
   logic [9:0] posx, posy;
   logic       frame_tick;

   sprite_motion_ctrl #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .SPRITE_W(SW), .SPRITE_H(SH),
      .STEP(STEP), .FRAMES_PER_MOVE(FPM), .X_INIT(XI), .Y_INIT(YI)
   ) dut (
      .clk(clk), .rst(rst), .pixelx(pixelx), .pixely(pixely),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .auto_en(auto_en), .posx(posx), .posy(posy), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ox;
      int oy;
      int nx;
      int ny;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   int mx, my, mcnt;
   bit mdx, mdy, armed;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      mx = XI; my = YI; mdx = 1; mdy = 1; mcnt = 0; armed = 0;
   endtask

   task automatic model_move();
      int n;
      if (auto_en) begin
         if (mdx) begin
            n = mx + STEP;
            if (n >= XMAX) begin mx = XMAX; mdx = 0; end else mx = n;
         end else if (mx <= STEP) begin mx = 0; mdx = 1; end
         else mx = mx - STEP;
         if (mdy) begin
            n = my + STEP;
            if (n >= YMAX) begin my = YMAX; mdy = 0; end else my = n;
         end else if (my <= STEP) begin my = 0; mdy = 1; end
         else my = my - STEP;
      end else begin
         if (btn_right != btn_left) mx = clampi(mx + (btn_right ? STEP : -STEP), XMAX);
         if (btn_down != btn_up)    my = clampi(my + (btn_down ? STEP : -STEP), YMAX);
      end
   endtask

   task automatic set_in(input bit a, input bit u, input bit d, input bit l, input bit r);
      auto_en = a; btn_up = u; btn_down = d; btn_left = l; btn_right = r;
   endtask

   // One compressed frame: visible lines ending at 479, then blanking.
   // rst_at > 0 pulses reset rst_at edges after the blanking-entry edge.
   task automatic do_frame(input int rst_at, input int rst_len);
      int   vis, blk;
      exp_t e;
      bit   r;
      vis = $urandom_range(5, 10);
      blk = $urandom_range(4, 9);
      if (rst_at + rst_len > blk) blk = rst_at + rst_len;
      for (int i = 0; i < vis; i++) begin
         pixely = (i == vis - 1) ? 10'd479 : 10'($urandom_range(0, 478));
         pixelx = 10'($urandom_range(0, 799));
         step();
         armed = 1;
      end
      if (armed) begin
         e.ox = mx; e.oy = my;
         if (mcnt == FPM - 1) begin
            mcnt = 0;
            if (rst_at != 1) model_move();
         end else mcnt++;
         if (rst_at == 1) begin e.nx = XI; e.ny = YI; end
         else begin e.nx = mx; e.ny = my; end
         exp_q.push_back(e);
         armed = 0;
      end
      if (rst_at > 0) model_reset();
      for (int j = 0; j < blk; j++) begin
         pixely = 10'($urandom_range(480, 524));
         pixelx = 10'($urandom_range(0, 799));
         r = (rst_at > 0) && (j >= rst_at) && (j < rst_at + rst_len);
         rst = r;
         step();
         if (r) begin
            check("rst_tick", int'(frame_tick), 0);
            check("rst_posx", int'(posx), XI);
            check("rst_posy", int'(posy), YI);
         end
      end
      rst = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) do_frame(0, 0);
   endtask

   // Monitor: every tick pops one prediction, checks width and the committed origin.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_tick", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("pre_posx", int'(posx), e.ox);
               check("pre_posy", int'(posy), e.oy);
               @(negedge clk);
               check("tick_width", int'(frame_tick), 0);
               check("new_posx", int'(posx), e.nx);
               check("new_posy", int'(posy), e.ny);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      pixelx = '0;
      pixely = 10'd470;
      set_in(0, 0, 0, 0, 0);
      // Reset held while the scan sweeps across the 479->480 boundary.
      for (int i = 0; i < 10; i++) begin
         pixely = 10'(470 + 2 * i);
         step();
         check("init_tick", int'(frame_tick), 0);
         check("init_posx", int'(posx), XI);
         check("init_posy", int'(posy), YI);
      end
      rst = 1'b0;
      pixely = 10'd490;
      step();
      step();
      check("hold_no_tick", int'(frame_tick), 0);
      model_reset();

      // Bounce from reset: both axes reach their walls on the same update.
      set_in(1, 0, 0, 0, 0);
      frames(2 * 12);
      // Buttons: right, then opposing up+down, then long up and right to the clamps.
      set_in(0, 0, 0, 0, 1);
      frames(2 * 8);
      set_in(0, 1, 1, 0, 0);
      frames(2 * 2);
      set_in(0, 1, 0, 0, 0);
      frames(2 * 106);
      set_in(0, 0, 0, 1, 1);
      frames(2 * 2);
      set_in(0, 0, 1, 0, 1);
      frames(2 * 40);
      // Resets landing on the update edge and just after it.
      if (mcnt != FPM - 1) do_frame(0, 0);
      do_frame(1, 2);
      set_in(0, 0, 0, 1, 0);
      frames(3);
      if (mcnt != FPM - 1) do_frame(0, 0);
      do_frame(3, 2);
      frames(4);

      // Random phase: mode flips, button mixes, occasional mid-blanking resets.
      for (int f = 0; f < 300; f++) begin
         if ($urandom_range(0, 3) == 0)
            set_in(auto_en, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 9) == 0) do_frame($urandom_range(1, 3), $urandom_range(1, 3));
         else do_frame(0, 0);
      end

      pixely = 10'd100;
      for (int i = 0; i < 6; i++) step();
      check("pending_ticks", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous position controller for the sprite renderer. It watches the scan coordinates from the VGA timing generator and detects the start of vertical blanking. Once per N frames it computes a new sprite origin, either from push-buttons or from an autonomous bouncing motion, and drives the `posx`/`posy` inputs of the sprite datapath. Positions only change during blanking, so a frame is never drawn with a torn sprite.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `SPRITE_W`, 64: sprite width.
- `SPRITE_H`, 64: sprite height.
- `STEP`, 4: pixels moved per update; 1..63.
- `FRAMES_PER_MOVE`, 1: blanking entries per position update; ≥1.
- `X_INIT`, 288: reset X origin.
- `Y_INIT`, 208: reset Y origin.

Ports:
- `clk`  in  1: single clock, pixel clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `pixelx`  in  10: current scan X.
- `pixely`  in  10: current scan Y.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each: asynchronous, active-high buttons.
- `auto_en`  in  1: 1 selects bounce mode; 0 selects button mode.
- `posx`  out  10: sprite origin X.
- `posy`  out  10: sprite origin Y.
- `frame_tick`  out  1: one-cycle pulse on each blanking entry.

## Operation
- `vblank = (pixely >= V_ACTIVE)` is combinational.
- Buttons and `auto_en` each pass through a 2-flop synchronizer. Only the synchronized values are used.
- Bounds: `XMAX = H_ACTIVE - SPRITE_W` (576) and `YMAX = V_ACTIVE - SPRITE_H` (416). Arithmetic uses an 11-bit signed intermediate, so no wrap-around is possible.
- FSM states are HOLD, ACTIVE and UPDATE.
  - HOLD: wait for `vblank = 0`, then go to ACTIVE.
  - ACTIVE: when `vblank = 1`, assert `frame_tick` on the next cycle.
    - If `frame_cnt == FRAMES_PER_MOVE-1`: clear `frame_cnt` and go to UPDATE.
    - Otherwise: increment `frame_cnt` and go to HOLD.
  - UPDATE: commit the new `posx`/`posy`, then go to HOLD.
- Button mode, per axis:
  - Exactly one direction held: move by `STEP`, clamped to `[0, XMAX]` or `[0, YMAX]`.
  - Both directions held, or neither: no change on that axis.
- Bounce mode, per axis, with direction registers `dirx`/`diry` (1 = increasing):
  - Increasing: `new = pos + STEP`. If `new >= max`, set `pos = max` and clear `dir`.
  - Decreasing: if `pos <= STEP`, set `pos = 0` and set `dir`. Otherwise `pos -= STEP`.
  - The axes are independent, so a corner hit flips both directions in the same UPDATE.
- `auto_en` is sampled only in UPDATE. Changing mode never resets `dirx`/`diry`.
- `posx`/`posy` change only in the UPDATE state.

## Timing
- Reset values while `rst` is high, and on the first edge after it falls:
  - `posx = X_INIT`, `posy = Y_INIT`
  - `frame_tick = 0`
  - `dirx = diry = 1`
  - `frame_cnt = 0`
  - state = HOLD
  - synchronizer flops = 0
- Because reset enters HOLD, a reset asserted mid-blanking produces no tick or update until the next visible-to-blanking transition.
- Let edge k be the first edge at which ACTIVE samples `vblank = 1`.
  - `frame_tick` is high exactly from edge k to edge k+1.
  - `posx`/`posy` hold their new values after edge k+1.
  - Latency from blanking entry to new position is 2 cycles.
- Button latency is 2 cycles of synchronizer plus the wait for the next UPDATE. A press shorter than 2 cycles may be missed.
- `frame_tick` fires exactly once per frame, even when `pixely` dwells in blanking for many lines. `pixely` returning below `V_ACTIVE` re-arms detection.
- A `rst` pulse during UPDATE wins: positions return to their init values.

## Test plan
- Reset:
  - Stimulus: hold `rst` for 10 cycles while the timing generator sweeps, then release.
  - Required: `posx=288`, `posy=208`, `frame_tick=0` throughout reset. First tick occurs at the next `pixely` 479→480 transition.
- Button right:
  - Stimulus: `auto_en=0`, `btn_right` held for 3 frames, `STEP=4`.
  - Required: `posx` goes 292, 296, 300. `posy` stays 208. Exactly 3 `frame_tick` pulses, each 1 cycle wide.
- Clamping:
  - Stimulus: preload `posx=574` and hold right for 2 frames. Then `posy=2` and hold up.
  - Required: right gives `posx` 576, then 576. Up gives `posy` 0. Holding up and down together leaves `posy` unchanged.
- Bounce:
  - Stimulus: `auto_en=1`, `posx=568`, `dirx=1`.
  - Required: `posx` goes 572, 576 (dirx→0), 572, 568. Corner case: `posx=576`, `posy=416` with both directions increasing flips both in one UPDATE.
- Frame divider:
  - Stimulus: `FRAMES_PER_MOVE=2`, right held for 4 frames.
  - Required: 4 ticks and 2 moves (`posx` 292 after the 2nd tick, 296 after the 4th).
- Mid-blanking reset:
  - Stimulus: assert `rst` at `pixely=490`.
  - Required: no tick for the rest of that blanking period. The next tick occurs at the following 479→480 transition.
